// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: FSM encodings,
// default timing parameters and the round-robin pointer helper.
package uart_tx_scheduler_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ACCEPT    = 3'd1;
  localparam logic [2:0] S_STROBE    = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_ABORT     = 3'd5;

  // Clock/baud figures shared with uart_transceiver; the write strobe must
  // outlast one 16x baud tick (CLK_FREQ / (BAUDRATE*16) ~= 27 clk).
  localparam int CLK_FREQ        = 50_000_000;
  localparam int BAUDRATE        = 115_200;
  localparam int WR_HOLD_DEF     = 32;
  localparam int TIMEOUT_CYC_DEF = 16384;

  // Next requester after idx, wrapping n-1 -> 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr.
module uart_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [PW-1:0]      pick_idx
);

  int   idx;
  logic found;

  // Walk the requesters starting at ptr; the first valid one wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        pick[idx] = 1'b1;
        pick_idx  = PW'(idx);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_transceiver transmit path among NUM_REQ byte streams.
// Frames (bytes up to req_last) are granted round-robin and never preempted.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WR_HOLD     = WR_HOLD_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 uart_cs_n,
  output logic                 uart_rd_n,
  output logic [7:0]           uart_wdata,
  output logic                 uart_wdata_oe,
  input  logic                 uart_tx_idle,
  input  logic                 uart_tx_ok
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + WR_HOLD + 1);

  logic [2:0]         state;
  logic [PW-1:0]      ptr, gidx, pick_idx, nxt_ptr;
  logic [NUM_REQ-1:0] pick;
  logic [CW-1:0]      cnt;
  logic               last_q;
  logic [1:0]         idle_sync;
  logic [2:0]         ok_sync;
  logic               idle_s, ok_rise, done, tmo;
  logic               sel_valid, sel_last;
  logic [7:0]         sel_data;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid    (req_valid),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Bring the baud-domain status into clk; tx_ok keeps a third stage for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_sync <= '0;
      ok_sync   <= '0;
    end else begin
      idle_sync <= {idle_sync[0], uart_tx_idle};
      ok_sync   <= {ok_sync[1:0], uart_tx_ok};
    end
  end

  assign idle_s  = idle_sync[1];
  assign ok_rise = ok_sync[1] & ~ok_sync[2];

  // Route the granted requester's byte lane; grant is one-hot so at most one matches.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*8 +: 8];
      end
    end
  end

  assign nxt_ptr = PW'(rr_next(int'(gidx), NUM_REQ));
  // A tx_ok rise while still waiting for busy means the byte already went out.
  assign done = ((state == S_WAIT_BUSY) && ok_rise) ||
                ((state == S_WAIT_DONE) && (ok_rise || idle_s));
  assign tmo  = (cnt == CW'(TIMEOUT_CYC - 1));

  assign req_ready   = (state == S_ACCEPT) ? (grant & req_valid) : '0;
  assign busy        = (state != S_IDLE);
  assign timeout_err = (state == S_ABORT);
  assign uart_rd_n   = 1'b1;

  // Frame FSM; cnt serves as both strobe-hold and wait timeout and restarts on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      gidx          <= '0;
      ptr           <= '0;
      cnt           <= '0;
      last_q        <= 1'b0;
      uart_cs_n     <= 1'b1;
      uart_wdata_oe <= 1'b0;
      uart_wdata    <= '0;
    end else begin
      cnt <= (state == S_IDLE) ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            gidx  <= pick_idx;
            state <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (sel_valid) begin
            uart_wdata    <= sel_data;
            last_q        <= sel_last;
            uart_cs_n     <= 1'b0;
            uart_wdata_oe <= 1'b1;
            state         <= S_STROBE;
            cnt           <= '0;
          end else if (tmo) begin
            grant <= '0;
            state <= S_ABORT;
            cnt   <= '0;
          end
        end
        S_STROBE: begin
          if (cnt == CW'(WR_HOLD - 1)) begin
            uart_cs_n     <= 1'b1;
            uart_wdata_oe <= 1'b0;
            state         <= S_WAIT_BUSY;
            cnt           <= '0;
          end
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if (done) begin
            cnt <= '0;
            if (last_q) begin
              ptr   <= nxt_ptr;
              grant <= '0;
              state <= S_IDLE;
            end else begin
              state <= S_ACCEPT;
            end
          end else if ((state == S_WAIT_BUSY) && !idle_s) begin
            state <= S_WAIT_DONE;
            cnt   <= '0;
          end else if (tmo) begin
            grant <= '0;
            state <= S_ABORT;
            cnt   <= '0;
          end
        end
        S_ABORT: begin
          ptr   <= nxt_ptr;
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues, a simple
// transceiver model and a bus monitor feed hand-computed checks.
module tb_uart_tx_scheduler;

  localparam int TMO = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        busy, timeout_err, uart_cs_n, uart_rd_n, uart_wdata_oe;
  logic [7:0]  uart_wdata;
  logic        uart_tx_idle, uart_tx_ok;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NUM_REQ(4), .WR_HOLD(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .busy(busy), .timeout_err(timeout_err),
    .uart_cs_n(uart_cs_n), .uart_rd_n(uart_rd_n), .uart_wdata(uart_wdata),
    .uart_wdata_oe(uart_wdata_oe), .uart_tx_idle(uart_tx_idle), .uart_tx_ok(uart_tx_ok)
  );

  int total = 0;
  int bad   = 0;

  // requester side
  logic [7:0] q_data [4][$];
  bit         q_last [4][$];
  int         gap_cfg [4];
  int         gap_cnt [4];
  bit         taken [4];
  int         acc_idx [$];
  int         multi_rdy = 0;
  int         cyc = 0;
  int         rdy_cyc = 0;

  // bus monitor
  int         stb_len [$];
  logic [7:0] stb_byte [$];
  int         stb_lat [$];
  int         low_len = 0;
  logic [7:0] low_byte;
  int         oe_bad = 0, rd_bad = 0, tmo_cnt = 0;

  // transceiver model
  bit xcvr_en = 1'b1;
  bit xcvr_busy = 1'b0;

  typedef struct packed {
    logic [3:0]      mask;
    logic [2:0]      n;
    logic [3:0][1:0] ord;
  } rr_vec_t;

  rr_vec_t vecs [7];

  function automatic rr_vec_t mk(input logic [3:0] m, input int n,
                                 input int o0, input int o1, input int o2, input int o3);
    rr_vec_t v;
    v.mask   = m;
    v.n      = 3'(n);
    v.ord[0] = 2'(o0);
    v.ord[1] = 2'(o1);
    v.ord[2] = 2'(o2);
    v.ord[3] = 2'(o3);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input bit l);
    q_data[i].push_back(b);
    q_last[i].push_back(l);
  endtask

  task automatic sync();
    @(negedge clk);
    #4;
  endtask

  task automatic clear_logs();
    acc_idx.delete();
    stb_len.delete();
    stb_byte.delete();
    stb_lat.delete();
  endtask

  function automatic bit quiet();
    bit q = (busy === 1'b0) && !xcvr_busy;
    for (int i = 0; i < 4; i++)
      if (q_data[i].size() != 0 || taken[i] || gap_cnt[i] != 0) q = 1'b0;
    return q;
  endfunction

  task automatic run_quiet(input int budget, input string nm);
    int n = 0;
    bit q = 1'b0;
    while (!q && n < budget) begin
      @(negedge clk);
      #3;
      n++;
      q = quiet();
    end
    chk(nm, 32'(q), 1);
  endtask

  task automatic wait_cs(input logic v, input int budget, input string nm);
    int n = 0;
    while (uart_cs_n !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(uart_cs_n), 32'(v));
  endtask

  // Check the k-th accepted requester and the k-th byte seen on the bus.
  task automatic chk_acc(input string nm, input int k, input int ei, input logic [7:0] eb);
    int         ai = -1;
    logic [7:0] ab = 8'hxx;
    if (k < acc_idx.size()) ai = acc_idx[k];
    if (k < stb_byte.size()) ab = stb_byte[k];
    chk($sformatf("%s%0d_idx", nm, k), ai, ei);
    chk($sformatf("%s%0d_byte", nm, k), 32'(ab), 32'(eb));
  endtask

  // Requester driver: present queue heads, pop one negedge after a ready is seen.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < 4; i++) begin
      gap_cfg[i] = 0;
      gap_cnt[i] = 0;
      taken[i]   = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (taken[i]) begin
          taken[i] = 1'b0;
          if (q_data[i].size() > 0) begin
            q_data[i].delete(0);
            q_last[i].delete(0);
          end
          if (q_data[i].size() > 0) gap_cnt[i] = gap_cfg[i];
        end
        if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
          req_valid[i] = 1'b0;
        end else if (q_data[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = q_data[i][0];
          req_last[i]        = q_last[i][0];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      #2;
      if ($countones(req_ready) > 1) multi_rdy++;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] === 1'b1) begin
          taken[i] = 1'b1;
          acc_idx.push_back(i);
          rdy_cyc = cyc;
        end
      end
    end
  end

  // Bus monitor: strobe lengths/bytes, ready-to-strobe latency, invariants.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (uart_wdata_oe !== ~uart_cs_n) oe_bad++;
        if (uart_rd_n !== 1'b1) rd_bad++;
        if (timeout_err === 1'b1) tmo_cnt++;
      end
      if (uart_cs_n === 1'b0) begin
        if (low_len == 0) stb_lat.push_back(cyc - rdy_cyc);
        low_len++;
        low_byte = uart_wdata;
      end else if (low_len > 0) begin
        stb_len.push_back(low_len);
        stb_byte.push_back(low_byte);
        low_len = 0;
      end
    end
  end

  // Transceiver model: goes busy shortly after the strobe, then pulses ok and returns idle.
  initial begin
    uart_tx_idle = 1'b1;
    uart_tx_ok   = 1'b0;
    forever begin
      @(negedge clk);
      if (xcvr_en && uart_cs_n === 1'b0) begin
        xcvr_busy  = 1'b1;
        uart_tx_ok = 1'b0;
        repeat (10) @(negedge clk);
        uart_tx_idle = 1'b0;
        repeat (60) @(negedge clk);
        uart_tx_idle = 1'b1;
        uart_tx_ok   = 1'b1;
        xcvr_busy    = 1'b0;
      end
    end
  end

  initial begin
    int n;
    vecs[0] = mk(4'b1000, 1, 3, 0, 0, 0);
    vecs[1] = mk(4'b1111, 4, 0, 1, 2, 3);
    vecs[2] = mk(4'b0101, 2, 0, 2, 0, 0);
    vecs[3] = mk(4'b0110, 2, 1, 2, 0, 0);
    vecs[4] = mk(4'b1001, 2, 3, 0, 0, 0);
    vecs[5] = mk(4'b0001, 1, 0, 0, 0, 0);
    vecs[6] = mk(4'b1111, 4, 1, 2, 3, 0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_cs_n", 32'(uart_cs_n), 1);
    chk("rst_rd_n", 32'(uart_rd_n), 1);
    chk("rst_wdata", 32'(uart_wdata), 0);
    chk("rst_oe", 32'(uart_wdata_oe), 0);
    rst = 1'b0;

    // single byte from req0
    clear_logs();
    sync();
    push(0, 8'h55, 1);
    run_quiet(2000, "single_quiet");
    chk("single_count", acc_idx.size(), 1);
    chk_acc("single", 0, 0, 8'h55);
    chk("single_len", (stb_len.size() > 0) ? stb_len[0] : -1, 32);
    chk("single_lat", (stb_lat.size() > 0) ? stb_lat[0] : -1, 1);
    chk("single_grant_end", 32'(grant), 0);

    // frame lock: req1 3-byte frame with req2 waiting
    clear_logs();
    sync();
    push(1, 8'hA1, 0);
    push(1, 8'hA2, 0);
    push(1, 8'hA3, 1);
    push(2, 8'hB0, 1);
    run_quiet(3000, "lock_quiet");
    chk("lock_count", acc_idx.size(), 4);
    chk_acc("lock", 0, 1, 8'hA1);
    chk_acc("lock", 1, 1, 8'hA2);
    chk_acc("lock", 2, 1, 8'hA3);
    chk_acc("lock", 3, 2, 8'hB0);

    // round-robin table
    for (int r = 0; r < 7; r++) begin
      clear_logs();
      sync();
      for (int i = 0; i < 4; i++)
        if (vecs[r].mask[i]) push(i, 8'(16 * (r + 1) + i), 1);
      run_quiet(3000, $sformatf("rr%0d_quiet", r));
      chk($sformatf("rr%0d_count", r), acc_idx.size(), 32'(vecs[r].n));
      for (int k = 0; k < int'(vecs[r].n); k++)
        chk_acc($sformatf("rr%0d_", r), k, int'(vecs[r].ord[k]),
                8'(16 * (r + 1) + int'(vecs[r].ord[k])));
    end

    // timeout: transceiver never goes busy
    clear_logs();
    xcvr_en = 1'b0;
    sync();
    push(1, 8'h3C, 1);
    push(2, 8'h4D, 1);
    wait_cs(1'b0, 200, "tmo_cs_low");
    wait_cs(1'b1, 200, "tmo_cs_high");
    n = 0;
    while (timeout_err !== 1'b1 && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_delay", 32'(n >= TMO && n <= TMO + 4), 1);
    chk("tmo_pulse", 32'(timeout_err), 1);
    chk("tmo_grant", 32'(grant), 0);
    xcvr_en = 1'b1;
    @(negedge clk);
    chk("tmo_pulse_end", 32'(timeout_err), 0);
    run_quiet(2000, "tmo_quiet");
    chk("tmo_count", acc_idx.size(), 2);
    chk_acc("tmo", 0, 1, 8'h3C);
    chk_acc("tmo", 1, 2, 8'h4D);
    chk("tmo_pulses", tmo_cnt, 1);

    // reset mid-strobe
    clear_logs();
    sync();
    push(0, 8'h77, 1);
    wait_cs(1'b0, 200, "mrst_cs_low");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_cs_n", 32'(uart_cs_n), 1);
    chk("mrst_oe", 32'(uart_wdata_oe), 0);
    chk("mrst_grant", 32'(grant), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_wdata", 32'(uart_wdata), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    repeat (100) @(negedge clk);
    clear_logs();
    // pointer back at 0: req1 must win over req3
    sync();
    push(1, 8'h61, 1);
    push(3, 8'h63, 1);
    run_quiet(2000, "mrst_quiet");
    chk("mrst_count", acc_idx.size(), 2);
    chk_acc("mrst", 0, 1, 8'h61);
    chk_acc("mrst", 1, 3, 8'h63);

    // gap: req3 stalls between bytes, req0 waits for the frame to finish
    clear_logs();
    gap_cfg[3] = 180;
    sync();
    push(3, 8'hD1, 0);
    push(3, 8'hD2, 0);
    push(3, 8'hD3, 1);
    n = 0;
    while (acc_idx.size() < 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("gap_first", acc_idx.size(), 1);
    sync();
    push(0, 8'hE0, 1);
    repeat (150) @(negedge clk);
    chk("gap_grant_held", 32'(grant), 32'h8);
    chk("gap_busy", 32'(busy), 1);
    chk("gap_no_ready", 32'(req_ready), 0);
    run_quiet(3000, "gap_quiet");
    gap_cfg[3] = 0;
    chk("gap_count", acc_idx.size(), 4);
    chk_acc("gap", 0, 3, 8'hD1);
    chk_acc("gap", 1, 3, 8'hD2);
    chk_acc("gap", 2, 3, 8'hD3);
    chk_acc("gap", 3, 0, 8'hE0);
    chk("gap_no_abort", tmo_cnt, 1);

    // whole-run invariants
    chk("multi_ready", multi_rdy, 0);
    chk("oe_vs_cs", oe_bad, 0);
    chk("rd_n_high", rd_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
